display_mode_ctrl: RTL and testbench

Sequencer that owns the 2-bit `sel` input of the 4-mode seven-segment display multiplexer. It advances the displayed mode on a debounced push-button press, or automatically after a programmable dwell time, and skips disabled modes. On every mode change it blanks the display for a short window so downstream decoders never show a half-switched frame. It sits between the board pushbutton/switch inputs and the display mux select.

---
 rtl/display_mode_ctrl_if.sv | 30 +++
 rtl/display_mode_ctrl.sv | 173 +++++++++++++++++
 tb/tb_display_mode_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/display_mode_ctrl_if.sv
// Board-side bundle for the display mode sequencer: raw key, auto-advance
// enable, per-mode enables going in; mux select, blanking and strobe coming out.
interface display_mode_ctrl_if;
  logic       key_next_n;
  logic       auto_en;
  logic [3:0] mode_en;
  logic [1:0] sel;
  logic       blank;
  logic       mode_stb;

  // Driven by the board/pushbutton side.
  modport master (
    output key_next_n,
    output auto_en,
    output mode_en,
    input  sel,
    input  blank,
    input  mode_stb
  );

  // Driven by the sequencer.
  modport slave (
    input  key_next_n,
    input  auto_en,
    input  mode_en,
    output sel,
    output blank,
    output mode_stb
  );
endinterface

// File: rtl/display_mode_ctrl.sv
// Display mode sequencer: owns the 2-bit select of the seven-segment mux.
// A debounced key press, a dwell timeout or the current mode being disabled
// moves to the next enabled mode, with a blanking window around every change.
module display_mode_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DWELL_CYCLES    = 100000000,
  parameter int BLANK_CYCLES    = 2500000
) (
  input logic                clk,
  input logic                rst,
  display_mode_ctrl_if.slave bus
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DW_W = $clog2(DWELL_CYCLES + 1);
  localparam int BL_W = $clog2(BLANK_CYCLES + 1);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL_CYCLES - 1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLANK_CYCLES - 1);

  typedef enum logic {
    ST_SHOW,
    ST_BLANK
  } state_t;

  logic            r_keySync1;
  logic            r_keyS;
  logic            r_keyDb;
  logic            r_keyDbDly;
  logic [DB_W-1:0] r_dbCnt;

  state_t          r_state;
  logic [DW_W-1:0] r_dwellCnt;
  logic [BL_W-1:0] r_blankCnt;
  logic [1:0]      r_pending;
  logic [1:0]      r_sel;
  logic            r_blank;
  logic            r_modeStb;

  logic            w_pressEvt;
  logic [1:0]      w_idx;
  logic [1:0]      w_target;
  logic            w_targetValid;
  logic            w_dwellExpire;
  logic            w_advanceReq;

  state_t          w_stateNxt;
  logic [DW_W-1:0] w_dwellNxt;
  logic [BL_W-1:0] w_blankCntNxt;
  logic [1:0]      w_pendingNxt;
  logic [1:0]      w_selNxt;
  logic            w_blankNxt;
  logic            w_modeStbNxt;

  // Two-flop synchronizer bringing the asynchronous key into the clock domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_keySync1 <= 1'b1;
      r_keyS     <= 1'b1;
    end else begin
      r_keySync1 <= bus.key_next_n;
      r_keyS     <= r_keySync1;
    end
  end

  // Accept a new key level only after it has differed from the accepted level long enough.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_keyDb    <= 1'b1;
      r_keyDbDly <= 1'b1;
      r_dbCnt    <= '0;
    end else begin
      r_keyDbDly <= r_keyDb;
      if (r_keyS != r_keyDb) begin
        if (r_dbCnt == DB_LAST) begin
          r_keyDb <= r_keyS;
          r_dbCnt <= '0;
        end else begin
          r_dbCnt <= r_dbCnt + DB_W'(1);
        end
      end else begin
        r_dbCnt <= '0;
      end
    end
  end

  assign w_pressEvt = r_keyDbDly & ~r_keyDb;

  // Search sel+1, sel+2, sel+3 for the nearest enabled mode; the descending loop lets the nearest win.
  always_comb begin
    w_idx         = r_sel;
    w_target      = r_sel;
    w_targetValid = 1'b0;
    for (int k = 3; k >= 1; k--) begin
      w_idx = r_sel + 2'(k);
      if (bus.mode_en[w_idx]) begin
        w_target      = w_idx;
        w_targetValid = 1'b1;
      end
    end
  end

  assign w_dwellExpire = bus.auto_en && (r_dwellCnt == DW_LAST);
  assign w_advanceReq  = w_pressEvt || w_dwellExpire || !bus.mode_en[r_sel];

  // Next-state and next-output logic: requests are only honoured while showing a mode.
  always_comb begin
    w_stateNxt    = r_state;
    w_dwellNxt    = r_dwellCnt;
    w_blankCntNxt = r_blankCnt;
    w_pendingNxt  = r_pending;
    w_selNxt      = r_sel;
    w_blankNxt    = 1'b0;
    w_modeStbNxt  = 1'b0;
    case (r_state)
      ST_SHOW: begin
        w_dwellNxt    = bus.auto_en ? (r_dwellCnt + DW_W'(1)) : '0;
        w_blankCntNxt = '0;
        if (w_advanceReq) begin
          w_dwellNxt = '0;
          if (w_targetValid) begin
            w_pendingNxt = w_target;
            w_stateNxt   = ST_BLANK;
            w_blankNxt   = 1'b1;
          end
        end
      end
      ST_BLANK: begin
        w_dwellNxt = '0;
        w_blankNxt = 1'b1;
        if (r_blankCnt == BL_LAST) begin
          w_selNxt      = r_pending;
          w_modeStbNxt  = 1'b1;
          w_blankNxt    = 1'b0;
          w_stateNxt    = ST_SHOW;
          w_blankCntNxt = '0;
        end else begin
          w_blankCntNxt = r_blankCnt + BL_W'(1);
        end
      end
      default: begin
        w_stateNxt = ST_SHOW;
      end
    endcase
  end

  // State, counters and registered outputs; reset abandons any transition in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_SHOW;
      r_dwellCnt <= '0;
      r_blankCnt <= '0;
      r_pending  <= 2'd0;
      r_sel      <= 2'd0;
      r_blank    <= 1'b0;
      r_modeStb  <= 1'b0;
    end else begin
      r_state    <= w_stateNxt;
      r_dwellCnt <= w_dwellNxt;
      r_blankCnt <= w_blankCntNxt;
      r_pending  <= w_pendingNxt;
      r_sel      <= w_selNxt;
      r_blank    <= w_blankNxt;
      r_modeStb  <= w_modeStbNxt;
    end
  end

  assign bus.sel      = r_sel;
  assign bus.blank    = r_blank;
  assign bus.mode_stb = r_modeStb;

endmodule

// File: tb/tb_display_mode_ctrl.sv
// Directed bench for display_mode_ctrl with short debounce/dwell/blank
// parameters; expected values are hand-derived edge numbers.
module tb_display_mode_ctrl;

  localparam int DEB   = 4;
  localparam int DWELL = 20;
  localparam int BLK   = 3;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  bit   quiet;
  int   stbCount;

  display_mode_ctrl_if bus ();

  display_mode_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .DWELL_CYCLES   (DWELL),
    .BLANK_CYCLES   (BLK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic keyN, input logic autoEn, input logic [3:0] modeEn);
    bus.key_next_n = keyN;
    bus.auto_en    = autoEn;
    bus.mode_en    = modeEn;
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [1:0] expSel, input logic expBlank, input logic expStb);
    checkOutput({tag, " sel"}, {2'b00, bus.sel}, {2'b00, expSel});
    checkOutput({tag, " blank"}, {3'b000, bus.blank}, {3'b000, expBlank});
    checkOutput({tag, " stb"}, {3'b000, bus.mode_stb}, {3'b000, expStb});
  endtask

  task automatic watchQuiet(input int n, input logic [1:0] expSel);
    for (int i = 0; i < n; i++) begin
      stepCycles(1);
      if (bus.sel !== expSel || bus.blank !== 1'b0 || bus.mode_stb !== 1'b0) quiet = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 4'b1111);
    stepCycles(2);
    rst = 1'b0;
    checkAll("reset", 2'd0, 1'b0, 1'b0);
    quiet = 1'b1;
    watchQuiet(50, 2'd0);
    checkOutput("idle quiet", {3'b000, quiet}, 4'd1);

    $display("[TB] short key pulse");
    applyStimulus(1'b0, 1'b0, 4'b1111);
    stepCycles(3);
    applyStimulus(1'b1, 1'b0, 4'b1111);
    quiet = 1'b1;
    watchQuiet(15, 2'd0);
    checkOutput("short pulse ignored", {3'b000, quiet}, 4'd1);

    $display("[TB] debounced press");
    applyStimulus(1'b0, 1'b0, 4'b1111);
    for (int e = 0; e <= 14; e++) begin
      stepCycles(1);
      checkAll($sformatf("press e%0d", e),
               (e >= 10) ? 2'd1 : 2'd0,
               (e >= 7 && e <= 9) ? 1'b1 : 1'b0,
               (e == 10) ? 1'b1 : 1'b0);
      if (e == 9) applyStimulus(1'b1, 1'b0, 4'b1111);
    end
    quiet = 1'b1;
    watchQuiet(20, 2'd1);
    checkOutput("release quiet", {3'b000, quiet}, 4'd1);

    $display("[TB] auto-advance with skip");
    rst = 1'b1;
    stepCycles(1);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b1, 4'b1011);
    for (int e = 0; e <= 70; e++) begin
      stepCycles(1);
      checkAll($sformatf("auto e%0d", e),
               (e < 22) ? 2'd0 : (e < 45) ? 2'd1 : (e < 68) ? 2'd3 : 2'd0,
               ((e >= 19 && e <= 21) || (e >= 42 && e <= 44) || (e >= 65 && e <= 67)) ? 1'b1 : 1'b0,
               (e == 22 || e == 45 || e == 68) ? 1'b1 : 1'b0);
    end

    $display("[TB] no valid target");
    quiet = 1'b1;
    applyStimulus(1'b1, 1'b0, 4'b0001);
    watchQuiet(2, 2'd0);
    applyStimulus(1'b0, 1'b0, 4'b0001);
    watchQuiet(10, 2'd0);
    applyStimulus(1'b1, 1'b0, 4'b0001);
    watchQuiet(12, 2'd0);
    applyStimulus(1'b1, 1'b1, 4'b0001);
    watchQuiet(40, 2'd0);
    checkOutput("single mode quiet", {3'b000, quiet}, 4'd1);

    quiet = 1'b1;
    applyStimulus(1'b1, 1'b0, 4'b0000);
    watchQuiet(2, 2'd0);
    applyStimulus(1'b0, 1'b0, 4'b0000);
    watchQuiet(10, 2'd0);
    applyStimulus(1'b1, 1'b0, 4'b0000);
    watchQuiet(12, 2'd0);
    applyStimulus(1'b1, 1'b1, 4'b0000);
    watchQuiet(40, 2'd0);
    checkOutput("no mode quiet", {3'b000, quiet}, 4'd1);

    $display("[TB] forced advance");
    applyStimulus(1'b1, 1'b0, 4'b0100);
    stepCycles(1);
    checkAll("force0 f0", 2'd0, 1'b1, 1'b0);
    stepCycles(2);
    checkAll("force0 f2", 2'd0, 1'b1, 1'b0);
    stepCycles(1);
    checkAll("force0 f3", 2'd2, 1'b0, 1'b1);
    stepCycles(1);
    checkAll("at sel2", 2'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'b1001);
    stepCycles(1);
    checkAll("force1 f0", 2'd2, 1'b1, 1'b0);
    stepCycles(2);
    checkAll("force1 f2", 2'd2, 1'b1, 1'b0);
    stepCycles(1);
    checkAll("force1 f3", 2'd3, 1'b0, 1'b1);

    $display("[TB] press during blank");
    applyStimulus(1'b1, 1'b0, 4'b1111);
    stepCycles(2);
    stbCount = 0;
    applyStimulus(1'b0, 1'b0, 4'b1111);
    for (int e = 0; e <= 30; e++) begin
      stepCycles(1);
      if (bus.mode_stb === 1'b1) stbCount++;
      if (e == 7) checkOutput("drop blank e7", {3'b000, bus.blank}, 4'd1);
      if (e == 9) checkAll("drop e9", 2'd0, 1'b0, 1'b1);
      if (e == 5) applyStimulus(1'b0, 1'b0, 4'b0111);
      if (e == 10) applyStimulus(1'b1, 1'b0, 4'b0111);
    end
    checkOutput("drop stb count", 4'(stbCount), 4'd1);
    checkOutput("drop final sel", {2'b00, bus.sel}, 4'd0);

    $display("[TB] reset mid-transition");
    applyStimulus(1'b1, 1'b0, 4'b1110);
    stepCycles(1);
    checkOutput("mid f0 blank", {3'b000, bus.blank}, 4'd1);
    stepCycles(1);
    checkOutput("mid f1 blank", {3'b000, bus.blank}, 4'd1);
    rst = 1'b1;
    stepCycles(1);
    checkAll("mid reset", 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 4'b1111);
    stepCycles(1);
    checkAll("after reset", 2'd0, 1'b0, 1'b0);
    quiet = 1'b1;
    watchQuiet(6, 2'd0);
    checkOutput("abandoned quiet", {3'b000, quiet}, 4'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
